// File: rtl/raycast_column_scheduler.sv
// Per-frame column sequencer: ray launch -> ray done -> height lookup -> clamped buffer write, per column.
// Column period 1 + R + H + 1 cycles; waits saturate at TIMEOUT and write height 0, so a frame always completes.
module raycast_column_scheduler #(
  parameter int NUM_COLS   = 640,
  parameter int MAX_HEIGHT = 480,
  parameter int TIMEOUT    = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       setup_complete,
  input  logic       frame_req,
  output logic       ray_start,
  output logic [9:0] ray_col,
  input  logic       ray_done,
  output logic       write_new_frame,
  input  logic       height_valid,
  input  logic [9:0] wall_height,
  output logic       col_we,
  output logic [9:0] col_addr,
  output logic [9:0] col_data,
  output logic       frame_busy,
  output logic       frame_done,
  output logic       timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_RAY,
    S_WAIT_HEIGHT,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [9:0] LAST_COL  = 10'(NUM_COLS - 1);
  localparam logic [9:0] MAX_H     = 10'(MAX_HEIGHT);
  localparam logic [9:0] WAIT_LAST = 10'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic       pending_q, pending_d;
  logic [9:0] col_q, col_d;
  logic [9:0] wait_cnt_q, wait_cnt_d;
  logic       ray_start_q, ray_start_d;
  logic       write_new_frame_q, write_new_frame_d;
  logic       col_we_q, col_we_d;
  logic [9:0] col_addr_q, col_addr_d;
  logic [9:0] col_data_q, col_data_d;
  logic       frame_busy_q, frame_busy_d;
  logic       frame_done_q, frame_done_d;
  logic       timeout_err_q, timeout_err_d;

  logic [9:0] clamped_height;
  logic       wait_expired;

  assign clamped_height = (wall_height > MAX_H) ? MAX_H : wall_height;
  // wait_cnt_q counts earlier cycles in this wait state; expiry lands on the TIMEOUT-th cycle.
  assign wait_expired   = (wait_cnt_q >= WAIT_LAST);

  always_comb begin
    state_d           = state_q;
    pending_d         = pending_q | frame_req;
    col_d             = col_q;
    wait_cnt_d        = (wait_cnt_q == 10'h3FF) ? wait_cnt_q : wait_cnt_q + 10'd1;
    ray_start_d       = 1'b0;
    write_new_frame_d = write_new_frame_q;
    col_we_d          = 1'b0;
    col_addr_d        = col_addr_q;
    col_data_d        = col_data_q;
    frame_done_d      = 1'b0;
    timeout_err_d     = timeout_err_q;

    case (state_q)
      S_IDLE: begin
        if (pending_q && setup_complete) begin
          state_d           = S_LAUNCH;
          pending_d         = frame_req;
          col_d             = 10'd0;
          ray_start_d       = 1'b1;
          write_new_frame_d = 1'b1;
        end
      end
      S_LAUNCH: begin
        state_d    = S_WAIT_RAY;
        wait_cnt_d = 10'd0;
      end
      S_WAIT_RAY: begin
        if (ray_done) begin
          state_d    = S_WAIT_HEIGHT;
          wait_cnt_d = 10'd0;
        end else if (wait_expired) begin
          state_d       = S_WRITE;
          timeout_err_d = 1'b1;
          col_we_d      = 1'b1;
          col_addr_d    = col_q;
          col_data_d    = 10'd0;
        end
      end
      S_WAIT_HEIGHT: begin
        if (height_valid || wait_expired) begin
          state_d       = S_WRITE;
          timeout_err_d = timeout_err_q | ~height_valid;
          col_we_d      = 1'b1;
          col_addr_d    = col_q;
          col_data_d    = height_valid ? clamped_height : 10'd0;
        end
      end
      S_WRITE: begin
        if (col_q == LAST_COL) begin
          state_d      = S_DONE;
          frame_done_d = 1'b1;
        end else begin
          state_d     = S_LAUNCH;
          col_d       = col_q + 10'd1;
          ray_start_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d           = S_IDLE;
        write_new_frame_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    frame_busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= S_IDLE;
      pending_q         <= 1'b0;
      col_q             <= 10'd0;
      wait_cnt_q        <= 10'd0;
      ray_start_q       <= 1'b0;
      write_new_frame_q <= 1'b0;
      col_we_q          <= 1'b0;
      col_addr_q        <= 10'd0;
      col_data_q        <= 10'd0;
      frame_busy_q      <= 1'b0;
      frame_done_q      <= 1'b0;
      timeout_err_q     <= 1'b0;
    end else begin
      state_q           <= state_d;
      pending_q         <= pending_d;
      col_q             <= col_d;
      wait_cnt_q        <= wait_cnt_d;
      ray_start_q       <= ray_start_d;
      write_new_frame_q <= write_new_frame_d;
      col_we_q          <= col_we_d;
      col_addr_q        <= col_addr_d;
      col_data_q        <= col_data_d;
      frame_busy_q      <= frame_busy_d;
      frame_done_q      <= frame_done_d;
      timeout_err_q     <= timeout_err_d;
    end
  end

  assign ray_start       = ray_start_q;
  assign ray_col         = col_q;
  assign write_new_frame = write_new_frame_q;
  assign col_we          = col_we_q;
  assign col_addr        = col_addr_q;
  assign col_data        = col_data_q;
  assign frame_busy      = frame_busy_q;
  assign frame_done      = frame_done_q;
  assign timeout_err     = timeout_err_q;

endmodule

// File: tb/tb_raycast_column_scheduler.sv
// Randomized bench for raycast_column_scheduler against a frame-level scoreboard model.
module tb_raycast_column_scheduler;
  localparam int NC   = 4;
  localparam int MAXH = 480;
  localparam int TMO  = 8;

  logic       clk = 1'b0;
  logic       rst, setup_complete, frame_req, ray_done, height_valid;
  logic [9:0] wall_height;
  logic       ray_start, write_new_frame, col_we, frame_busy, frame_done, timeout_err;
  logic [9:0] ray_col, col_addr, col_data;

  raycast_column_scheduler #(.NUM_COLS(NC), .MAX_HEIGHT(MAXH), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .setup_complete(setup_complete), .frame_req(frame_req),
    .ray_start(ray_start), .ray_col(ray_col), .ray_done(ray_done),
    .write_new_frame(write_new_frame), .height_valid(height_valid), .wall_height(wall_height),
    .col_we(col_we), .col_addr(col_addr), .col_data(col_data),
    .frame_busy(frame_busy), .frame_done(frame_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {int col; int data; int cyc; bit tmo;} exp_t;
  exp_t exp_q[$];

  int errors = 0, checks = 0, n = 0, frames_done = 0;
  int cfg_r[NC], cfg_h[NC], cfg_ht[NC];
  bit cfg_dr[NC], cfg_dh[NC], cfg_both[NC];
  bit spur_en = 1'b0;

  // Frame-level model: pending request, idle/busy, expected event cycles.
  bit m_idle = 1'b1, m_pend = 1'b0, m_terr = 1'b0;
  int m_col = 0, m_wr = 0, m_rs_at = -1, m_done_at = -1, m_idle_at = -1;

  // Ray engine / lookup responder schedule.
  int rd_at = -1, hv_at = -1, both_at = -1, env_col = -1, cur_ht = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, n, got, exp);
    end
  endtask

  function automatic int clamp_h(input int h);
    return (h > MAXH) ? MAXH : h;
  endfunction

  task automatic cyc();
    bit   p_req, p_setup, p_rst, start, exp_we, quiet;
    exp_t e;
    p_req = frame_req; p_setup = setup_complete; p_rst = rst;
    @(posedge clk); #1;
    n++;
    if (p_rst) begin
      check_val("rst_ray_col", ray_col, 0);
      check_val("rst_col_addr", col_addr, 0);
      check_val("rst_col_data", col_data, 0);
      m_idle = 1'b1; m_pend = 1'b0; m_terr = 1'b0; exp_q.delete();
      m_rs_at = -1; m_done_at = -1; m_idle_at = -1; m_col = 0; m_wr = 0;
    end else begin
      start  = m_idle && m_pend && p_setup;
      m_pend = start ? p_req : (m_pend || p_req);
      if (start) begin m_idle = 1'b0; m_rs_at = n; m_col = 0; m_wr = 0; end
      if (n == m_idle_at) m_idle = 1'b1;
    end

    check_val("frame_busy", frame_busy, !m_idle);
    check_val("write_new_frame", write_new_frame, !m_idle);
    check_val("ray_start", ray_start, n == m_rs_at);
    if (ray_start && n == m_rs_at) begin
      check_val("ray_col", ray_col, m_col);
      env_col = m_col;
      e.col   = m_col;
      e.tmo   = cfg_dr[m_col] || cfg_dh[m_col];
      e.data  = e.tmo ? 0 : clamp_h(cfg_ht[m_col]);
      if (cfg_dr[m_col]) begin
        rd_at = -1; hv_at = -1; e.cyc = n + TMO + 1;
      end else begin
        rd_at = n + cfg_r[m_col];
        hv_at = cfg_dh[m_col] ? -1 : rd_at + cfg_h[m_col];
        e.cyc = cfg_dh[m_col] ? rd_at + TMO + 1 : hv_at + 1;
      end
      both_at = (cfg_both[m_col] && !cfg_dr[m_col]) ? rd_at : -1;
      cur_ht  = cfg_ht[m_col];
      exp_q.push_back(e);
    end

    exp_we = (exp_q.size() > 0) && (exp_q[0].cyc == n);
    check_val("col_we", col_we, exp_we);
    if (exp_we) begin
      e = exp_q.pop_front();
      check_val("col_addr", col_addr, e.col);
      check_val("col_data", col_data, e.data);
      check_val("ray_col_hold", ray_col, e.col);
      if (e.tmo) m_terr = 1'b1;
      m_wr++;
      if (m_wr == NC) begin m_done_at = n + 1; m_idle_at = n + 2; end
      else begin m_col++; m_rs_at = n + 1; end
    end
    check_val("frame_done", frame_done, n == m_done_at);
    if (frame_done) frames_done++;
    check_val("timeout_err", timeout_err, m_terr);

    // Spurious pulses only where the controller must ignore them.
    quiet        = spur_en && (m_idle || exp_we);
    ray_done     = (n == rd_at) || (quiet && $urandom_range(0, 2) == 0);
    height_valid = (n == hv_at) || (n == both_at) || (quiet && $urandom_range(0, 2) == 0);
    wall_height  = (n == hv_at) ? 10'(cur_ht) : 10'($urandom_range(0, 1023));
  endtask

  task automatic idle(input int k);
    repeat (k) cyc();
  endtask

  task automatic req();
    frame_req = 1'b1; cyc(); frame_req = 1'b0;
  endtask

  task automatic wait_until(input int target);
    for (int i = 0; i < 800 && frames_done < target; i++) cyc();
    check_val("frame_wait", frames_done, target);
  endtask

  task automatic cfg_fixed(input int r, input int h);
    for (int c = 0; c < NC; c++) begin
      cfg_r[c] = r; cfg_h[c] = h; cfg_ht[c] = 100 * (c + 1);
      cfg_dr[c] = 1'b0; cfg_dh[c] = 1'b0; cfg_both[c] = 1'b0;
    end
  endtask

  initial begin
    int base;
    bit hit;
    rst = 1'b1; setup_complete = 1'b0; frame_req = 1'b0;
    ray_done = 1'b0; height_valid = 1'b0; wall_height = '0;
    cfg_fixed(3, 2);
    idle(3);
    rst = 1'b0;
    idle(3);

    // Normal frame: heights 100..400, 7-cycle column period.
    setup_complete = 1'b1;
    req(); wait_until(frames_done + 1); idle(5);

    // Clamping, same-cycle ray_done/height_valid, spurious pulses.
    spur_en = 1'b1;
    cfg_ht[0] = 700; cfg_ht[1] = 480; cfg_ht[2] = 481; cfg_ht[3] = 1023;
    cfg_both[1] = 1'b1;
    req(); wait_until(frames_done + 1); idle(5);

    // Ray timeout on column 1, then height timeout on column 2.
    cfg_fixed(3, 2); cfg_dr[1] = 1'b1;
    req(); wait_until(frames_done + 1); idle(4);
    cfg_fixed(2, 2); cfg_dh[2] = 1'b1;
    req(); wait_until(frames_done + 1); idle(4);
    rst = 1'b1; idle(2); rst = 1'b0; idle(2);

    // Two requests during a frame merge into one extra frame.
    cfg_fixed(3, 2);
    base = frames_done;
    req(); idle(8); req(); idle(5); req();
    wait_until(base + 2); idle(30);
    check_val("queued_frames", frames_done, base + 2);

    // Request blocked until setup completes; setup drop mid-frame is harmless.
    setup_complete = 1'b0;
    req(); idle(15);
    check_val("setup_block_busy", frame_busy, 0);
    setup_complete = 1'b1;
    wait_until(frames_done + 1); idle(3);
    req(); idle(6); setup_complete = 1'b0;
    wait_until(frames_done + 1); setup_complete = 1'b1; idle(4);

    // Reset during WAIT_HEIGHT of column 2; the late height must not write.
    cfg_fixed(2, 3);
    req();
    hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      cyc();
      if (env_col == 2 && n == rd_at + 1) hit = 1'b1;
    end
    check_val("rst_point_reached", hit, 1);
    rst = 1'b1; cyc(); rst = 1'b0;
    idle(20);

    // Randomized frames.
    for (int f = 0; f < 10; f++) begin
      for (int c = 0; c < NC; c++) begin
        cfg_r[c]    = $urandom_range(1, 6);
        cfg_h[c]    = $urandom_range(1, 4);
        cfg_ht[c]   = $urandom_range(0, 1023);
        cfg_dr[c]   = ($urandom_range(0, 7) == 0);
        cfg_dh[c]   = ($urandom_range(0, 7) == 0);
        cfg_both[c] = ($urandom_range(0, 3) == 0);
      end
      req(); wait_until(frames_done + 1); idle($urandom_range(1, 4));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/raycast_column_scheduler.md
# raycast_column_scheduler

Frame-level controller that sequences the ray engine and the wall-height lookup one screen column at a time. On each frame request it launches a ray for column 0 and waits for the ray to finish and for the height lookup to return. It then writes the clamped height into the column buffer and advances, up to column NUM_COLS-1. It sits between the frame timing logic, the DDA ray engine, the height lookup stage and the column height buffer read by the renderer.

## Interface
- NUM_COLS, 640, columns per frame (1..1024)
- MAX_HEIGHT, 480, saturation limit for written heights
- TIMEOUT, 1023, max cycles waited in any wait state (1..1023)
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- setup_complete  in  1  map/player setup done; no frame starts while low
- frame_req  in  1  one-cycle pulse requesting a new frame
- ray_start  out  1  one-cycle pulse launching the ray for ray_col
- ray_col  out  10  column index of the current ray
- ray_done  in  1  one-cycle pulse from the ray engine
- write_new_frame  out  1  high from first ray_start to frame_done; gates the height lookup
- height_valid  in  1  one-cycle pulse from the height lookup (height_found_d)
- wall_height  in  10  height from the lookup, valid with height_valid
- col_we  out  1  column buffer write strobe
- col_addr  out  10  column buffer address
- col_data  out  10  column buffer data
- frame_busy  out  1  high in any state other than IDLE
- frame_done  out  1  one-cycle pulse after the last column write
- timeout_err  out  1  sticky; set on any wait timeout, cleared only by rst

## Operation
- States: IDLE, LAUNCH, WAIT_RAY, WAIT_HEIGHT, WRITE, DONE.
- IDLE: if pending && setup_complete, set col=0, clear pending, go to LAUNCH.
- LAUNCH: assert ray_start for 1 cycle with ray_col=col, clear wait counter, go to WAIT_RAY.
- WAIT_RAY: on ray_done go to WAIT_HEIGHT. If the counter reaches TIMEOUT, set timeout_err, load height 0, go to WRITE.
- WAIT_HEIGHT: on height_valid capture wall_height, go to WRITE. On timeout, set timeout_err, load 0, go to WRITE.
- WRITE: col_we=1, col_addr=col, col_data=min(captured, MAX_HEIGHT). If col==NUM_COLS-1 go to DONE; else col++ and go to LAUNCH.
- DONE: pulse frame_done, drop write_new_frame, go to IDLE.
- Pending flag: set by frame_req in any state. It is one deep; extra requests merge into it. A frame_req arriving during a frame is serviced right after DONE.
- ray_done outside WAIT_RAY and height_valid outside WAIT_HEIGHT are ignored.
- The wait counter is 10 bits and saturates; it does not wrap.
- Column counter: 10 bits, never exceeds NUM_COLS-1.
- A setup_complete drop mid-frame does not abort the frame. It only blocks the next start.
- Height compare is unsigned 10-bit. Values above MAX_HEIGHT are written as MAX_HEIGHT.

## Timing
- Reset values: state IDLE, pending 0, all outputs 0, ray_col 0, col_addr 0, col_data 0.
- rst during a frame: next cycle is IDLE with all outputs 0 and pending cleared. No further col_we.
- Frame start: the first ray_start occurs 2 cycles after a frame_req seen in IDLE with setup_complete high (req edge → IDLE sees pending → LAUNCH).
- write_new_frame rises with the first ray_start and falls the cycle after frame_done.
- ray_col is stable from ray_start through the column's WRITE.
- Per-column latency: 1 (LAUNCH) + R + H + 1 (WRITE) cycles.
  - R = cycles from ray_start to ray_done.
  - H = cycles from ray_done to height_valid; nominally 2 with the current lookup.
  - With R=H=2 the column period is 6 cycles, and a full 640-column frame completes in 3840 cycles plus 1 for DONE.
- ray_done and height_valid in the same cycle while in WAIT_RAY: only ray_done is taken. The FSM then waits in WAIT_HEIGHT for a new height_valid.
- col_we is a single-cycle pulse, exactly one per column, NUM_COLS per frame including timed-out columns.

## Test plan
- Normal frame: NUM_COLS=4, R=3, H=2, wall_height=100,200,300,400. Expect writes (0,100),(1,200),(2,300),(3,400), each 7 cycles apart, then frame_done once, and no timeout_err.
- Clamp: wall_height=700 with MAX_HEIGHT=480 → col_data=480.
- Ray timeout: TIMEOUT=8, no ray_done for column 1. Expect timeout_err set, col_data=0 at col_addr 1, and the frame still completes with NUM_COLS writes.
- Queued request: frame_req pulsed twice mid-frame → exactly one extra frame starts 1 cycle after frame_done. Separately, frame_req with setup_complete=0 → stays IDLE until setup_complete rises, then starts.
- Reset mid-frame: rst asserted during WAIT_HEIGHT of column 2 → next cycle all outputs 0, frame_busy=0, and a late height_valid causes no write.
- Spurious pulses: ray_done or height_valid injected in IDLE or WRITE → no state change and no extra col_we.
